box_filter_3x3: RTL and testbench

Streaming, parametrised 3×3 box (smoothing) filter for multi-channel raster pixel streams. It accepts one pixel per cycle in raster order and buffers two image lines per channel. For every fully populated 3×3 window it emits either the floor average or the raw sum of the nine samples. It sits between the pixel source and downstream edge or threshold stages, and supersedes the fixed two-channel, pre-windowed smoother.

---
 rtl/box_filter_3x3.sv | 138 +++++++++++++
 tb/tb_box_filter_3x3.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_filter_3x3.sv
// Streaming 3x3 box filter (floor average or raw sum) per channel, one pixel/cycle in raster order.
// Output 2 cycles after the completing pixel; no backpressure, so every out_valid cycle must be consumed.
module box_filter_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8,
  parameter int CH    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [CH*PIX_W-1:0]     in_pix,
  input  logic                    mode,
  output logic                    out_valid,
  output logic [CH*(PIX_W+4)-1:0] out_pix,
  output logic                    out_last
);

  localparam int SW = PIX_W + 4;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [SW-1:0] DIV_NINE = SW'(9);

  logic [CW-1:0]    r_col, w_col, w_col_nxt;
  logic [RW-1:0]    r_row, w_row, w_row_nxt;
  logic             w_complete, w_last;

  // Line A holds the previous row, line B the one before it.
  logic [PIX_W-1:0] r_lb_a [CH][IMG_W];
  logic [PIX_W-1:0] r_lb_b [CH][IMG_W];

  // Window indexed [channel][line][column]; line 0 is the oldest row, column 2 the newest pixel.
  logic [PIX_W-1:0] r_win     [CH][3][3];
  logic [PIX_W-1:0] w_col_new [CH][3];
  logic [SW-1:0]    w_sum     [CH];

  logic             r_s1_vld, r_s1_last, r_s1_mode;
  logic [SW-1:0]    r_s1_sum  [CH];
  logic [CH*SW-1:0] w_res;
  logic             r_out_vld, r_out_last;
  logic [CH*SW-1:0] r_out_pix;

  always_comb begin
    w_col     = in_sof ? '0 : r_col;
    w_row     = in_sof ? '0 : r_row;
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
    w_complete = in_valid && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
    w_last     = w_complete && (w_col == COL_LAST) && (w_row == ROW_LAST);
  end

  // The sum covers the window as it will look after this pixel shifts in.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      w_col_new[k][0] = r_lb_b[k][w_col];
      w_col_new[k][1] = r_lb_a[k][w_col];
      w_col_new[k][2] = in_pix[k*PIX_W +: PIX_W];
      w_sum[k] = '0;
      for (int r = 0; r < 3; r++) begin
        w_sum[k] = w_sum[k] + SW'(r_win[k][r][1]) + SW'(r_win[k][r][2]) + SW'(w_col_new[k][r]);
      end
    end
  end

  always_comb begin
    w_res = '0;
    for (int k = 0; k < CH; k++) begin
      w_res[k*SW +: SW] = r_s1_mode ? r_s1_sum[k] : (r_s1_sum[k] / DIV_NINE);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      for (int k = 0; k < CH; k++) begin
        r_lb_b[k][w_col] <= r_lb_a[k][w_col];
        r_lb_a[k][w_col] <= in_pix[k*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_pix  <= '0;
      for (int k = 0; k < CH; k++) begin
        r_s1_sum[k] <= '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            r_win[k][r][c] <= '0;
          end
        end
      end
    end else begin
      if (in_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        for (int k = 0; k < CH; k++) begin
          for (int r = 0; r < 3; r++) begin
            r_win[k][r][0] <= r_win[k][r][1];
            r_win[k][r][1] <= r_win[k][r][2];
            r_win[k][r][2] <= w_col_new[k][r];
          end
        end
      end
      r_s1_vld  <= w_complete;
      r_s1_last <= w_last;
      if (w_complete) begin
        r_s1_mode <= mode;
        r_s1_sum  <= w_sum;
      end
      r_out_vld  <= r_s1_vld;
      r_out_last <= r_s1_last;
      if (r_s1_vld) begin
        r_out_pix <= w_res;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;
  assign out_pix   = r_out_pix;

endmodule

// File: tb/tb_box_filter_3x3.sv
// Bench for box_filter_3x3: a 4x4 and a 5x4 instance driven in turn, checked against a frame-image model.
module tb_box_filter_3x3;

  logic        clk;
  logic        rst;
  logic        iv4, iv5;
  logic        in_sof;
  logic [15:0] in_pix;
  logic        mode;
  logic        out_valid4, out_last4, out_valid5, out_last5;
  logic [23:0] out_pix4, out_pix5;

  box_filter_3x3 #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .CH(2)) dut4 (
    .clk(clk), .reset(rst), .in_valid(iv4), .in_sof(in_sof), .in_pix(in_pix), .mode(mode),
    .out_valid(out_valid4), .out_pix(out_pix4), .out_last(out_last4));

  box_filter_3x3 #(.IMG_W(5), .IMG_H(4), .PIX_W(8), .CH(2)) dut5 (
    .clk(clk), .reset(rst), .in_valid(iv5), .in_sof(in_sof), .in_pix(in_pix), .mode(mode),
    .out_valid(out_valid5), .out_pix(out_pix5), .out_last(out_last5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int d;
    int v0;
    int v1;
    bit last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mrow[2];
  int   mcol[2];
  int   img[2][8][8][2];
  int   nrec = 0;
  int   rv0[256];
  int   rv1[256];
  int   rlast[256];

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: stores the frame as an image and sums the 3x3 neighbourhood ending at each accepted pixel.
  task automatic model_accept(input int d, input int W, input int H);
    int   r, c, s0, s1;
    exp_t e;
    r = in_sof ? 0 : mrow[d];
    c = in_sof ? 0 : mcol[d];
    img[d][r][c][0] = int'(in_pix[7:0]);
    img[d][r][c][1] = int'(in_pix[15:8]);
    if (r >= 2 && c >= 2) begin
      s0 = 0;
      s1 = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++) begin
          s0 += img[d][r-dr][c-dc][0];
          s1 += img[d][r-dr][c-dc][1];
        end
      e.due  = cyc + 1;
      e.d    = d;
      e.v0   = mode ? s0 : s0 / 9;
      e.v1   = mode ? s1 : s1 / 9;
      e.last = (r == H-1) && (c == W-1);
      q.push_back(e);
    end
    c++;
    if (c == W) begin
      c = 0;
      r++;
      if (r == H) r = 0;
    end
    mrow[d] = r;
    mcol[d] = c;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mrow[0] = 0; mcol[0] = 0; mrow[1] = 0; mcol[1] = 0;
    end else begin
      if (iv4) model_accept(0, 4, 4);
      if (iv5) model_accept(1, 5, 4);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      check("rst_vld4", out_valid4, 0);
      check("rst_vld5", out_valid5, 0);
      check("rst_last5", out_last5, 0);
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic        ov, ol;
        logic [23:0] op;
        ov = (d == 1) ? out_valid5 : out_valid4;
        ol = (d == 1) ? out_last5  : out_last4;
        op = (d == 1) ? out_pix5   : out_pix4;
        if (q.size() > 0 && q[0].d == d && q[0].due < cyc) begin
          check($sformatf("dut%0d_missed_due%0d", d, q[0].due), 0, 1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].d == d && q[0].due == cyc) begin
          check($sformatf("dut%0d_vld", d), ov, 1);
          check($sformatf("dut%0d_ch0", d), op[11:0], q[0].v0);
          check($sformatf("dut%0d_ch1", d), op[23:12], q[0].v1);
          check($sformatf("dut%0d_last", d), ol, q[0].last);
          if (nrec < 256) begin
            rv0[nrec]   = int'(op[11:0]);
            rv1[nrec]   = int'(op[23:12]);
            rlast[nrec] = int'(ol);
            nrec++;
          end
          void'(q.pop_front());
        end else begin
          check($sformatf("dut%0d_idle_vld", d), ov, 0);
          check($sformatf("dut%0d_idle_last", d), ol, 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iv4 = 1'b0; iv5 = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic drive_pix(input int d, input bit sof, input int p0, input int p1, input bit md);
    @(posedge clk); #1;
    iv4    = (d == 0);
    iv5    = (d == 1);
    in_sof = sof;
    in_pix = {8'(p1), 8'(p0)};
    mode   = md;
  endtask

  function automatic int pval(input int kind, input int r, input int c, input int ch, input int W);
    case (kind)
      0: return 9;
      1: return 255;
      2: if (ch == 0) return (r == 0 && c == 0) ? 17 : (r == 0 && c == 3) ? 8 : (r == 3 && c == 0) ? 26 : 0;
         else return (r == 3 && c == 3) ? 254 : 255;
      default: return (r * W + c) * (ch + 1);
    endcase
  endfunction

  task automatic send_frame(input int d, input int kind, input bit md, input int gap,
                            input bit sof, input int W, input int H);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while (gap > 0 && $urandom_range(0, 99) < gap) idle(1);
        drive_pix(d, sof && r == 0 && c == 0, pval(kind, r, c, 0, W), pval(kind, r, c, 1, W), md);
      end
  endtask

  task automatic check_ramp(input string tag, input int base);
    int e0[6] = '{6, 7, 8, 11, 12, 13};
    check({tag, "_count"}, nrec - base, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_ch0_%0d", tag, i), rv0[base+i], e0[i]);
      check($sformatf("%s_ch1_%0d", tag, i), rv1[base+i], 2 * e0[i]);
      check($sformatf("%s_last_%0d", tag, i), rlast[base+i], (i == 5) ? 1 : 0);
    end
  endtask

  initial begin
    int base;
    int f0[4] = '{1, 0, 2, 0};
    int f1[4] = '{255, 255, 255, 254};
    iv4 = 1'b0; iv5 = 1'b0; in_sof = 1'b0; in_pix = '0; mode = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_pix4", out_pix4, 0);
    check("reset_out_pix5", out_pix5, 0);
    check("reset_last4", out_last4, 0);
    rst = 1'b0;
    idle(2);

    base = nrec;
    send_frame(0, 0, 1'b0, 0, 1'b1, 4, 4);
    idle(5);
    check("const9_count", nrec - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("const9_ch0_%0d", i), rv0[base+i], 9);
      check($sformatf("const9_ch1_%0d", i), rv1[base+i], 9);
      check($sformatf("const9_last_%0d", i), rlast[base+i], (i == 3) ? 1 : 0);
    end

    base = nrec;
    send_frame(0, 1, 1'b1, 0, 1'b1, 4, 4);
    send_frame(0, 1, 1'b0, 0, 1'b1, 4, 4);
    idle(5);
    check("max_count", nrec - base, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("max_ch0_%0d", i), rv0[base+i], (i < 4) ? 2295 : 255);
      check($sformatf("max_ch1_%0d", i), rv1[base+i], (i < 4) ? 2295 : 255);
    end

    base = nrec;
    send_frame(0, 2, 1'b0, 0, 1'b1, 4, 4);
    idle(5);
    check("floor_count", nrec - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("floor_ch0_%0d", i), rv0[base+i], f0[i]);
      check($sformatf("floor_ch1_%0d", i), rv1[base+i], f1[i]);
    end

    base = nrec;
    send_frame(1, 3, 1'b0, 0, 1'b1, 5, 4);
    idle(5);
    check_ramp("ramp", base);

    base = nrec;
    send_frame(1, 3, 1'b0, 40, 1'b1, 5, 4);
    idle(5);
    check_ramp("ramp_gaps", base);

    base = nrec;
    for (int i = 0; i < 11; i++) drive_pix(1, i == 0, 200, 100, 1'b0);
    @(posedge clk); #1;
    iv5 = 1'b1; in_pix = 16'h3377; rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      iv5 = 1'b0;
    end
    check("midreset_out_vld", out_valid5, 0);
    rst = 1'b0;
    idle(2);
    send_frame(1, 3, 1'b0, 0, 1'b0, 5, 4);
    idle(5);
    check_ramp("after_reset", base);

    base = nrec;
    for (int i = 0; i < 8; i++) drive_pix(1, i == 0, 77, 199, 1'b0);
    send_frame(1, 3, 1'b0, 0, 1'b1, 5, 4);
    idle(5);
    check_ramp("sof_resync", base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
